// File: rtl/flash_mp_region_sel_seq.sv
// flash_mp_region_sel_seq: lowest-index address-window match with registered allow/deny response
module flash_mp_region_sel_seq #(
  parameter int NumRegions = 8,
  parameter int AddrW = 16,
  parameter int AttrW = 4,
  parameter logic [AttrW-1:0] DefaultAttr = '0,
  parameter logic [AttrW-1:0] HwDataAttr = AttrW'(1),
  parameter int RegIdxW = (NumRegions > 1) ? $clog2(NumRegions) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cfg_we_i,
  input  logic [RegIdxW-1:0]    cfg_idx_i,
  input  logic                  cfg_en_i,
  input  logic [AddrW-1:0]      cfg_base_i,
  input  logic [AddrW:0]        cfg_size_i,
  input  logic [AttrW-1:0]      cfg_attr_i,
  input  logic                  cfg_lock_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [AddrW-1:0]      req_addr_i,
  input  logic [1:0]            req_op_i,
  input  logic                  req_hw_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_allow_o,
  output logic                  rsp_hit_o,
  output logic [RegIdxW-1:0]    rsp_region_o,
  output logic [AttrW-1:0]      rsp_attr_o,
  output logic [7:0]            deny_cnt_o,
  output logic [NumRegions-1:0] lock_o
);
  logic [NumRegions-1:0] en_q, lock_q, match;
  logic [AddrW-1:0]      base_q [NumRegions];
  logic [AddrW:0]        size_q [NumRegions];
  logic [AttrW-1:0]      attr_q [NumRegions];
  logic                  hit, allow, accept;
  logic [RegIdxW-1:0]    idx;
  logic [AttrW-1:0]      attr;

  // Out-of-range indices match no region, so such writes fall through untouched
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q <= '0;
      lock_q <= '0;
      for (int i = 0; i < NumRegions; i++) begin
        base_q[i] <= '0;
        size_q[i] <= '0;
        attr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumRegions; i++) begin
        if (cfg_we_i && cfg_idx_i == RegIdxW'(i) && !lock_q[i]) begin
          en_q[i] <= cfg_en_i;
          base_q[i] <= cfg_base_i;
          size_q[i] <= cfg_size_i;
          attr_q[i] <= cfg_attr_i;
          lock_q[i] <= cfg_lock_i;
        end
      end
    end
  end

  // Window end is widened so base+size can never wrap
  for (genvar g = 0; g < NumRegions; g++) begin : g_match
    assign match[g] = en_q[g] && req_addr_i >= base_q[g] &&
                      (AddrW+2)'(req_addr_i) < (AddrW+2)'(base_q[g]) + (AddrW+2)'(size_q[g]);
  end

  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NumRegions - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit = 1'b1;
        idx = RegIdxW'(i);
      end
    end
  end

  assign attr = req_hw_i ? HwDataAttr : hit ? attr_q[idx] : DefaultAttr;
  assign allow = req_op_i != 2'd3 && attr[req_op_i];
  assign req_ready_o = !rsp_valid_o || rsp_ready_i;
  assign accept = req_valid_i && req_ready_o;
  assign lock_o = lock_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_o <= 1'b0;
      rsp_allow_o <= 1'b0;
      rsp_hit_o <= 1'b0;
      rsp_region_o <= '0;
      rsp_attr_o <= '0;
      deny_cnt_o <= '0;
    end else if (accept) begin
      rsp_valid_o <= 1'b1;
      rsp_allow_o <= allow;
      rsp_hit_o <= hit;
      rsp_region_o <= idx;
      rsp_attr_o <= attr;
      if (!allow && deny_cnt_o != 8'hFF) deny_cnt_o <= deny_cnt_o + 8'd1;
    end else if (rsp_ready_i) begin
      rsp_valid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_flash_mp_region_sel_seq.sv
// tb_flash_mp_region_sel_seq: directed and random requests against a window-table reference model
module tb_flash_mp_region_sel_seq;
  logic clk, rst_n, cfg_we, cfg_en, cfg_lock, req_valid, req_ready, req_hw;
  logic rsp_valid, rsp_ready, rsp_allow, rsp_hit;
  logic [2:0] cfg_idx, rsp_region;
  logic [15:0] cfg_base, req_addr;
  logic [16:0] cfg_size;
  logic [3:0] cfg_attr, rsp_attr;
  logic [1:0] req_op;
  logic [7:0] deny_cnt, lock;

  flash_mp_region_sel_seq dut (
    .clk_i(clk), .rst_ni(rst_n), .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_en_i(cfg_en),
    .cfg_base_i(cfg_base), .cfg_size_i(cfg_size), .cfg_attr_i(cfg_attr), .cfg_lock_i(cfg_lock),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr), .req_op_i(req_op),
    .req_hw_i(req_hw), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_allow_o(rsp_allow),
    .rsp_hit_o(rsp_hit), .rsp_region_o(rsp_region), .rsp_attr_o(rsp_attr),
    .deny_cnt_o(deny_cnt), .lock_o(lock)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int m_base [8], m_size [8];
  bit m_en [8];
  bit [3:0] m_attr [8];
  bit [7:0] m_lock;
  int e_deny, e_reg;
  bit e_hit, e_allow;
  bit [3:0] e_attr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_en[i] = 0; m_base[i] = 0; m_size[i] = 0; m_attr[i] = 0;
    end
    m_lock = 0;
    e_deny = 0;
  endtask

  task automatic model_cfg(input int idx, input bit en, input int base, input int size, input bit [3:0] attr, input bit lk);
    if (!m_lock[idx]) begin
      m_en[idx] = en; m_base[idx] = base; m_size[idx] = size; m_attr[idx] = attr;
      m_lock[idx] = lk;
    end
  endtask

  task automatic predict(input int addr, input int op, input bit hw);
    e_hit = 0;
    e_reg = 0;
    for (int i = 0; i < 8; i++)
      if (!e_hit && m_en[i] && addr >= m_base[i] && addr < m_base[i] + m_size[i]) begin
        e_hit = 1;
        e_reg = i;
      end
    e_attr = hw ? 4'b0001 : e_hit ? m_attr[e_reg] : 4'b0000;
    e_allow = (op < 3) && e_attr[op];
  endtask

  task automatic check_rsp(input string tag);
    chk({tag, ".valid"}, 32'(rsp_valid), 1);
    chk({tag, ".allow"}, 32'(rsp_allow), 32'(e_allow));
    chk({tag, ".hit"}, 32'(rsp_hit), 32'(e_hit));
    chk({tag, ".region"}, 32'(rsp_region), e_reg);
    chk({tag, ".attr"}, 32'(rsp_attr), 32'(e_attr));
    chk({tag, ".deny"}, 32'(deny_cnt), e_deny);
    chk({tag, ".lock"}, 32'(lock), 32'(m_lock));
  endtask

  task automatic count_deny();
    if (!e_allow && e_deny < 255) e_deny++;
  endtask

  task automatic cfg(input int idx, input bit en, input int base, input int size, input bit [3:0] attr, input bit lk);
    cfg_we = 1; cfg_idx = 3'(idx); cfg_en = en; cfg_base = 16'(base);
    cfg_size = 17'(size); cfg_attr = attr; cfg_lock = lk;
    @(posedge clk);
    model_cfg(idx, en, base, size, attr, lk);
    @(negedge clk);
    cfg_we = 0;
  endtask

  task automatic req(input int addr, input int op, input bit hw, input string tag);
    req_valid = 1; req_addr = 16'(addr); req_op = 2'(op); req_hw = hw;
    predict(addr, op, hw);
    #1 chk({tag, ".ready"}, 32'(req_ready), 1);
    @(posedge clk);
    count_deny();
    @(negedge clk);
    req_valid = 0;
    check_rsp(tag);
  endtask

  initial begin
    int addr, j;
    clk = 0; rst_n = 0; cfg_we = 0; cfg_idx = 0; cfg_en = 0; cfg_base = 0; cfg_size = 0;
    cfg_attr = 0; cfg_lock = 0; req_valid = 0; req_addr = 0; req_op = 0; req_hw = 0; rsp_ready = 1;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst.valid", 32'(rsp_valid), 0);
    chk("rst.ready", 32'(req_ready), 1);
    chk("rst.allow", 32'(rsp_allow), 0);
    chk("rst.hit", 32'(rsp_hit), 0);
    chk("rst.region", 32'(rsp_region), 0);
    chk("rst.attr", 32'(rsp_attr), 0);
    chk("rst.deny", 32'(deny_cnt), 0);
    chk("rst.lock", 32'(lock), 0);
    rst_n = 1;
    @(negedge clk);

    req('h0010, 0, 0, "miss0");
    cfg(2, 1, 'h0100, 'h40, 4'b0011, 0);
    req('h0100, 0, 0, "r2lo");
    req('h013F, 0, 0, "r2hi");
    req('h0140, 0, 0, "r2past");
    cfg(1, 1, 'h01F0, 'h20, 4'b0001, 0);
    cfg(4, 1, 'h0200, 'h100, 4'b0111, 0);
    req('h0200, 2, 0, "overlap");
    cfg(3, 1, 'h0300, 'h10, 4'b0111, 1);
    cfg(3, 1, 'h0300, 'h10, 4'b0000, 0);
    chk("lock3", 32'(lock), 'h08);
    req('h0305, 1, 0, "lockprog");
    cfg(5, 1, 'hFFF0, 'h10, 4'b0001, 0);
    req('hFFFF, 0, 0, "topend");
    cfg(6, 1, 'h0400, 0, 4'b0111, 0);
    req('h0400, 0, 0, "size0");
    req('h5000, 0, 1, "hwmiss");
    req('h0305, 3, 0, "op3");

    // config and request in the same cycle: request sees old table
    cfg_we = 1; cfg_idx = 0; cfg_en = 1; cfg_base = 'h0600; cfg_size = 'h10; cfg_attr = 4'b0001; cfg_lock = 0;
    req_valid = 1; req_addr = 'h0600; req_op = 0; req_hw = 0;
    predict('h0600, 0, 0);
    @(posedge clk);
    count_deny();
    model_cfg(0, 1, 'h0600, 'h10, 4'b0001, 0);
    @(negedge clk);
    cfg_we = 0; req_valid = 0;
    check_rsp("samecyc");
    req('h0600, 0, 0, "aftercfg");

    @(negedge clk);
    rsp_ready = 0;
    req('h0100, 0, 0, "stallA");
    req_valid = 1; req_addr = 'h013F; req_op = 1; req_hw = 0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("stall.ready", 32'(req_ready), 0);
      @(posedge clk);
      @(negedge clk);
      check_rsp("stallhold");
    end
    rsp_ready = 1;
    predict('h013F, 1, 0);
    #1 chk("release.ready", 32'(req_ready), 1);
    @(posedge clk);
    count_deny();
    @(negedge clk);
    check_rsp("stallB");
    req('h0200, 0, 0, "stallC");

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0)
        cfg($urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 65535),
            $urandom_range(0, 4096), 4'($urandom_range(0, 15)), $urandom_range(0, 15) == 0);
      j = $urandom_range(0, 7);
      addr = $urandom_range(0, 1) ? $urandom_range(0, 65535) : (m_base[j] + $urandom_range(0, m_size[j] + 1)) % 65536;
      req(addr, $urandom_range(0, 3), $urandom_range(0, 7) == 0, "rand");
    end

    for (int n = 0; n < 300; n++) req($urandom_range(0, 65535), 3, 0, "deny");
    chk("deny.sat", 32'(deny_cnt), 255);

    @(negedge clk);
    rsp_ready = 0;
    req('h0010, 0, 0, "prerst");
    #2 rst_n = 0;
    model_reset();
    #1;
    chk("midrst.valid", 32'(rsp_valid), 0);
    chk("midrst.deny", 32'(deny_cnt), 0);
    chk("midrst.lock", 32'(lock), 0);
    chk("midrst.ready", 32'(req_ready), 1);
    @(negedge clk);
    rst_n = 1;
    rsp_ready = 1;
    @(negedge clk);
    req('h0100, 0, 0, "postrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
